// File: rtl/wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_2to1
// Purpose  : Two-master, one-slave Wishbone classic arbiter. Whole bus cycles
//            (cyc high to cyc low) are granted round-robin between master 0
//            (instruction) and master 1 (data). An optional watchdog aborts a
//            strobe that stays unacknowledged for too long.
// Revision : 1.0 - initial release
//
// Configuration macro: WB_ARB_TIMEOUT_EN enables the stall watchdog.
//            When it is undefined, m0_err/m1_err are tied to 0 and stalls
//            wait forever.
//
// Parameters
//   TIMEOUT_CYCLES : stalled strobe cycles before abort (>= 2)
//   CNT_WIDTH      : watchdog counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk_core, rst_core          : clock, synchronous active-high reset
//   m0_* / m1_*                 : master-side Wishbone (cyc, stb, we, sel,
//                                 addr, data_w in; data_r, ack, err out)
//   s_*                         : slave-side Wishbone (cyc, stb, we, sel,
//                                 addr, data_w out; data_r, ack in)
// ============================================================================
module wb_arbiter_2to1 #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic        clk_core,
  input  logic        rst_core,
  // master 0 (instruction)
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_w,
  output logic [31:0] m0_data_r,
  output logic        m0_ack,
  output logic        m0_err,
  // master 1 (data)
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_w,
  output logic [31:0] m1_data_r,
  output logic        m1_ack,
  output logic        m1_err,
  // slave
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_w,
  input  logic [31:0] s_data_r,
  input  logic        s_ack
);

  // Elaboration-time parameter sanity check.
  if (TIMEOUT_CYCLES < 2 || CNT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_param_check
    $error("wb_arbiter_2to1: TIMEOUT_CYCLES must be >= 2 and fit in CNT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last;        // most recently granted master (0 or 1)
  logic   w_last_next;
  logic   w_req0;
  logic   w_req1;
  logic   w_abort;       // watchdog err cycle: slave strobe/cycle suppressed

  assign w_req0 = m0_cyc & m0_stb;
  assign w_req1 = m1_cyc & m1_stb;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state <= IDLE;
      r_last  <= 1'b1;   // so master 0 wins the first contention
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          if (r_last) begin
            w_state_next = GNT0;
            w_last_next  = 1'b0;
          end else begin
            w_state_next = GNT1;
            w_last_next  = 1'b1;
          end
        end else if (w_req0) begin
          w_state_next = GNT0;
          w_last_next  = 1'b0;
        end else if (w_req1) begin
          w_state_next = GNT1;
          w_last_next  = 1'b1;
        end
      end
      GNT0: begin
        // The grant is held for the whole bus cycle; release only on cyc low.
        if (!m0_cyc) begin
          if (w_req1) begin
            w_state_next = GNT1;
            w_last_next  = 1'b1;
          end else if (w_req0) begin
            // Unreachable while cyc is low; kept for a complete decision tree.
            w_state_next = GNT0;
            w_last_next  = 1'b0;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          if (w_req0) begin
            w_state_next = GNT0;
            w_last_next  = 1'b0;
          end else if (w_req1) begin
            w_state_next = GNT1;
            w_last_next  = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus multiplexing and acknowledge routing. Nothing is forwarded from IDLE,
  // so a new request always takes one cycle to reach the slave. Acks are
  // dropped while reset is asserted so an in-flight slave ack is discarded.
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = 4'h0;
    s_addr   = 32'h0;
    s_data_w = 32'h0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (r_state)
      GNT0: begin
        s_cyc    = m0_cyc & ~w_abort;
        s_stb    = m0_stb & ~w_abort;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_data_w = m0_data_w;
        m0_ack   = s_ack & m0_stb & ~w_abort & ~rst_core;
      end
      GNT1: begin
        s_cyc    = m1_cyc & ~w_abort;
        s_stb    = m1_stb & ~w_abort;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_data_w = m1_data_w;
        m1_ack   = s_ack & m1_stb & ~w_abort & ~rst_core;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_data_r = s_data_r;
  assign m1_data_r = s_data_r;

`ifdef WB_ARB_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Stall watchdog
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_wdog;
  logic                 r_err0;
  logic                 r_err1;
  logic                 w_gnt_stb;
  logic                 w_stall;

  assign w_gnt_stb = (r_state == GNT0) ? m0_stb :
                     (r_state == GNT1) ? m1_stb : 1'b0;

  // A stall cycle: the granted strobe is presented, not acknowledged, and the
  // grant does not change. Any other cycle clears the counter.
  assign w_stall = (r_state != IDLE) && (w_state_next == r_state) &&
                   w_gnt_stb && !s_ack && !w_abort;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_wdog <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      if (w_stall) begin
        // The count would reach TIMEOUT_CYCLES on this edge: raise err and
        // restart counting instead of storing the terminal value.
        if (r_wdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          r_wdog <= '0;
          r_err0 <= (r_state == GNT0);
          r_err1 <= (r_state == GNT1);
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign w_abort = r_err0 | r_err1;
  assign m0_err  = r_err0;
  assign m1_err  = r_err1;
`else
  assign w_abort = 1'b0;
  assign m0_err  = 1'b0;
  assign m1_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_2to1
// Purpose  : Self-checking bench for wb_arbiter_2to1. A bus-ownership model
//            predicts every output each cycle; directed scenarios add literal
//            expectations (single read, first contention, fairness, multi-beat
//            hold, reset mid-cycle and, with WB_ARB_TIMEOUT_EN, the watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2to1;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_data_w, m0_data_r;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_data_w, m1_data_r;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_data_w, s_data_r;
  logic        s_ack;
  logic        s_ack_drv;
  logic        auto_ack;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Slave: either directed ack or immediate ack of any strobe.
  assign s_ack = auto_ack ? s_stb : s_ack_drv;

  always #5 clk_core = ~clk_core;

  wb_arbiter_2to1 #(
    .TIMEOUT_CYCLES (4),
    .CNT_WIDTH      (3)
  ) dut (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_sel    (m0_sel),
    .m0_addr   (m0_addr),
    .m0_data_w (m0_data_w),
    .m0_data_r (m0_data_r),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_sel    (m1_sel),
    .m1_addr   (m1_addr),
    .m1_data_w (m1_data_w),
    .m1_data_r (m1_data_r),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_data_w  (s_data_w),
    .s_data_r  (s_data_r),
    .s_ack     (s_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Ownership model: who owns the bus (-1 nobody), who was served last, and
  // how long the owner's strobe has gone unanswered.
  // --------------------------------------------------------------------------
  int owner   = -1;
  int served  = 1;
  int stalled = 0;
  int err_who = -1;

  always @(posedge clk_core) begin
    int  nxt;
    bit  want0, want1;
    bit  own_cyc, own_stb, other_want;
    want0 = m0_cyc && m0_stb;
    want1 = m1_cyc && m1_stb;
    if (rst_core) begin
      owner = -1; served = 1; stalled = 0; err_who = -1;
    end else begin
      nxt        = owner;
      own_cyc    = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
      own_stb    = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
      other_want = (owner == 0) ? want1  : want0;
      if (owner < 0) begin
        if (want0 && want1) nxt = 1 - served;
        else if (want0)     nxt = 0;
        else if (want1)     nxt = 1;
      end else if (!own_cyc) begin
        nxt = other_want ? 1 - owner : -1;
      end
`ifdef WB_ARB_TIMEOUT_EN
      if (owner >= 0 && nxt == owner && own_stb && !s_ack && err_who < 0) begin
        stalled++;
        if (stalled == 4) begin
          stalled = 0;
          err_who = owner;
        end else begin
          err_who = -1;
        end
      end else begin
        stalled = 0;
        err_who = -1;
      end
`endif
      if (nxt >= 0 && nxt != owner) served = nxt;
      owner = nxt;
    end
  end

  always @(negedge clk_core) begin
    logic [6:0]  e_ctl;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_hs;
    bit          ab;
    if (cmp_en) begin
      ab     = (err_who >= 0);
      e_ctl  = '0;
      e_addr = '0;
      e_wd   = '0;
      e_hs   = '0;
      if (owner == 0) begin
        e_ctl   = {m0_cyc & !ab, m0_stb & !ab, m0_we, m0_sel};
        e_addr  = m0_addr;
        e_wd    = m0_data_w;
        e_hs[3] = s_ack & m0_stb & !ab & !rst_core;
      end else if (owner == 1) begin
        e_ctl   = {m1_cyc & !ab, m1_stb & !ab, m1_we, m1_sel};
        e_addr  = m1_addr;
        e_wd    = m1_data_w;
        e_hs[2] = s_ack & m1_stb & !ab & !rst_core;
      end
      e_hs[1] = (err_who == 0);
      e_hs[0] = (err_who == 1);
      chk("model_ctl",    {s_cyc, s_stb, s_we, s_sel}, e_ctl);
      chk("model_addr",   s_addr, e_addr);
      chk("model_data_w", s_data_w, e_wd);
      chk("model_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, e_hs);
      chk("model_data_r", {m0_data_r, m1_data_r}, {s_data_r, s_data_r});
    end
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_core);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "bench timeout");
  end

  initial begin
    int grant_log [8];
    int exp_seq   [8];
    int nlog;
    bit a0, a1;
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};

    rst_core = 1'b1; auto_ack = 1'b0; s_ack_drv = 1'b0; s_data_r = 32'h0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_addr = 0; m0_data_w = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_addr = 0; m1_data_w = 0;

    // ---------------- reset state
    step(); cmp_en = 1'b1; samp();
    chk("reset_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("reset_acks_errs", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);

    // ---------------- single master read
    step(); rst_core = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 32'h100;
    samp(); chk("t1_no_comb_grant", s_stb, 1'b0);
    step(); samp();
    chk("t1_s_stb", {s_cyc, s_stb}, 2'b11);
    chk("t1_s_addr", s_addr, 32'h100);
    step(); s_ack_drv = 1; s_data_r = 32'hDEADBEEF; samp();
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m0_data_r", m0_data_r, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_ack, 1'b0);
    step(); s_ack_drv = 0; m0_cyc = 0; m0_stb = 0; samp();
    chk("t1_release_s_cyc", s_cyc, 1'b0);
    step(); samp();

    // ---------------- simultaneous first request out of reset
    step(); rst_core = 1; samp();
    step(); rst_core = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'h3; m0_addr = 32'h200; m0_data_w = 32'h0;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hC; m1_addr = 32'h300; m1_data_w = 32'hCAFEF00D;
    samp(); chk("t2_no_comb_grant", s_stb, 1'b0);
    step(); s_ack_drv = 1; samp();
    chk("t2_m0_first_addr", s_addr, 32'h200);
    chk("t2_m0_first_acks", {m0_ack, m1_ack}, 2'b10);
    step(); s_ack_drv = 0; m0_cyc = 0; m0_stb = 0; samp();
    chk("t2_handover_s_cyc", s_cyc, 1'b0);
    step(); s_ack_drv = 1; samp();
    chk("t2_m1_ctl", {s_cyc, s_stb, s_we, s_sel}, {3'b111, 4'hC});
    chk("t2_m1_addr", s_addr, 32'h300);
    chk("t2_m1_data_w", s_data_w, 32'hCAFEF00D);
    chk("t2_m1_acks", {m0_ack, m1_ack}, 2'b01);
    step(); s_ack_drv = 0; m1_cyc = 0; m1_stb = 0; samp();
    step(); samp();

    // ---------------- fairness: both masters keep requesting 1-beat cycles
    auto_ack = 1;
    m0_addr = 32'h1000; m0_we = 0; m1_addr = 32'h2000; m1_we = 0;
    a0 = 0; a1 = 0; nlog = 0;
    for (int c = 0; c < 40 && nlog < 8; c++) begin
      step();
      m0_cyc = !a0; m0_stb = !a0;
      m1_cyc = !a1; m1_stb = !a1;
      samp();
      a0 = m0_ack; a1 = m1_ack;
      if (a0 && nlog < 8) begin grant_log[nlog] = 0; nlog++; end
      if (a1 && nlog < 8) begin grant_log[nlog] = 1; nlog++; end
    end
    chk("t3_grant_count", nlog, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < nlog) chk($sformatf("t3_grant_%0d", i), grant_log[i], exp_seq[i]);
    end
    step(); auto_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; samp();
    step(); samp();

    // ---------------- multi-beat hold by m1 while m0 waits
    step(); auto_ack = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 32'h3000; m1_data_w = 32'h11112222;
    samp();
    step(); m0_cyc = 1; m0_stb = 1; m0_addr = 32'h4000; samp();
    chk("t4_beat_acks", {m0_ack, m1_ack}, 2'b01);
    for (int b = 1; b < 4; b++) begin
      step(); samp();
      chk($sformatf("t4_beat%0d_acks", b), {m0_ack, m1_ack}, 2'b01);
      chk($sformatf("t4_beat%0d_addr", b), s_addr, 32'h3000);
    end
    step(); m1_cyc = 0; m1_stb = 0; samp();
    chk("t4_release", {s_cyc, m0_ack}, 2'b00);
    step(); samp();
    chk("t4_m0_stb", s_stb, 1'b1);
    chk("t4_m0_addr", s_addr, 32'h4000);
    chk("t4_m0_ack", m0_ack, 1'b1);
    step(); auto_ack = 0; m0_cyc = 0; m0_stb = 0; samp();
    step(); samp();

    // ---------------- reset in the middle of a pending m0 strobe
    step(); m0_cyc = 1; m0_stb = 1; m0_addr = 32'h5000; samp();
    step(); samp(); chk("t5_pending", {s_stb, m0_ack}, 2'b10);
    step(); rst_core = 1; s_ack_drv = 1; samp();
    chk("t5_ack_discarded", m0_ack, 1'b0);
    step(); rst_core = 0; s_ack_drv = 0;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h6000; samp();
    chk("t5_idle_ctl", {s_cyc, s_stb, s_we, s_sel}, 7'h0);
    chk("t5_idle_addr", s_addr, 32'h0);
    step(); samp(); chk("t5_m0_wins", s_addr, 32'h5000);
    step(); m0_cyc = 0; m0_stb = 0; samp();
    step(); samp(); chk("t5_m1_next", s_addr, 32'h6000);
    step(); m1_cyc = 0; m1_stb = 0; samp();
    step(); samp();

`ifdef WB_ARB_TIMEOUT_EN
    // ---------------- watchdog on a never-acknowledged m1 strobe
    step(); rst_core = 1; samp();
    step(); rst_core = 0; m1_cyc = 1; m1_stb = 1; m1_addr = 32'h7000; samp();
    for (int k = 1; k <= 4; k++) begin
      step(); samp();
      chk($sformatf("t6_stall%0d_err", k), {m1_err, s_stb}, 2'b01);
    end
    step(); s_ack_drv = 1; samp();
    chk("t6_err_pulse", {m0_err, m1_err}, 2'b01);
    chk("t6_err_bus", {s_cyc, s_stb}, 2'b00);
    chk("t6_late_ack_dropped", m1_ack, 1'b0);
    step(); s_ack_drv = 0; samp();
    chk("t6_err_single_cycle", {m1_err, s_stb}, 2'b01);
    step(); m1_cyc = 0; m1_stb = 0; samp();
    step(); samp();
`endif

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
